// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit and its FIFO.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    FULL    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of prefetched entries; flush clears pointers and count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 din,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher with redirect flush and abandoned-read discard.
module instr_prefetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [INSTR_WIDTH-1:0] i_mem_rdata,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
  input  logic                   i_take,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_WIDTH-1:0] target;
  logic                  push, pop;
  logic [CW-1:0]         count, count_nxt;
  entry_t                head, din;

  assign target    = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign push      = (state_q == FETCH) && i_mem_ack && !i_redirect;
  assign pop       = o_instr_valid && i_take && !i_redirect;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign din       = '{pc: req_addr_q, instr: i_mem_rdata};

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    pend_pc_d  = pend_pc_q;
    if (i_redirect) begin
      unique case (state_q)
        FETCH: begin
          if (i_mem_ack) begin
            req_addr_d = target;
          end else begin
            pend_pc_d = target;
            state_d   = DISCARD;
          end
        end
        DISCARD: begin
          pend_pc_d = target;
          if (i_mem_ack) begin
            req_addr_d = target;
            state_d    = FETCH;
          end
        end
        default: begin
          req_addr_d = target;
          state_d    = FETCH;
        end
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (i_mem_ack) begin
            req_addr_d = req_addr_q + ADDR_WIDTH'(4);
          end
          if (count_nxt == CW'(DEPTH)) begin
            state_d = FULL;
          end
        end
        FULL: begin
          if (count_nxt < CW'(DEPTH)) begin
            state_d = FETCH;
          end
        end
        DISCARD: begin
          // The abandoned read's data is simply not pushed.
          if (i_mem_ack) begin
            req_addr_d = pend_pc_q;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state_q    <= IDLE;
      req_addr_q <= RESET_PC;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .i_clk (i_clk),
    .i_arst(i_arst),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign o_mem_req     = (state_q == FETCH) || (state_q == DISCARD);
  assign o_mem_addr    = req_addr_q;
  assign o_instr_valid = (count != '0);
  assign o_instruction = o_instr_valid ? head.instr : INSTR_WIDTH'(NOP_INSTR);
  assign o_pc          = o_instr_valid ? head.pc : '0;
  assign o_pc_plus4    = o_pc + ADDR_WIDTH'(4);

endmodule
